rgmii_tx_if: RTL and testbench
==============================

RGMII_TX_IF -- requirements
Module: rgmii_tx_if

Interface
REQ-001 Parameter TARGET, default "GENERIC", selects DDR output primitive style: "SIM", "GENERIC", "XILINX" (7-series/UltraScale single-clock ODDR), "ALTERA".
REQ-002 Block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  125 MHz transmit clock; all logic is clocked on its rising edge, and the DDR falling-edge half-cycle also uses clk.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 gmii_txd  input  8  MAC transmit byte.
REQ-006 gmii_tx_en  input  1  MAC transmit enable.
REQ-007 gmii_tx_er  input  1  MAC transmit error.
REQ-008 speed  input  2  line rate: 00 = 10M, 01 = 100M, 10 = 1G, 11 treated as 1G.
REQ-009 mac_gmii_tx_clk_en  output  1  one-cycle strobe; MAC presents a new byte, captured on this cycle.
REQ-010 rgmii_tx_clk  output  1  forwarded clock, edge-aligned; the PHY adds the delay (TXID mode).
REQ-011 rgmii_txd  output  4  DDR data nibble.
REQ-012 rgmii_tx_ctl  output  1  DDR control: rising half = tx_en, falling half = tx_en XOR tx_er.

Function
REQ-013 Internal signals SHALL be one DDR pair per pad (hi-half value, lo-half value), registered into the oddr stage; the pad shows hi-half after the rising edge and lo-half after the falling edge.
REQ-014 1G mode SHALL behave as follows:
- mac_gmii_tx_clk_en is high every cycle.
- txd pair = (gmii_txd[3:0], gmii_txd[7:4]).
- ctl pair = (en, en^er).
- clk pair = (1,0).
REQ-015 1G latency SHALL be 2 clk cycles from byte sample edge to first pad nibble: one input register plus the oddr register.
REQ-016 10/100 mode SHALL use a period counter cnt running 0..N-1, wrapping to 0, with N = 5 (100M, 25 MHz) or N = 50 (10M, 2.5 MHz).
REQ-017 Clock pair for N = 5 SHALL be:
- cnt 0,1 -> (1,1)
- cnt 2 -> (1,0)
- cnt 3,4 -> (0,0)
This gives a 50% duty cycle.
REQ-018 Clock pair for N = 50 SHALL be (1,1) for cnt 0..24 and (0,0) for cnt 25..49.
REQ-019 A nibble_sel flag SHALL toggle when cnt wraps.
REQ-020 mac_gmii_tx_clk_en SHALL pulse for one cycle when cnt == N-1 and nibble_sel == 1, i.e. once per 2N cycles; the byte and its en/er are captured into a holding register on that cycle.
REQ-021 During the period with nibble_sel = 0, txd pair SHALL be (byte[3:0], byte[3:0]); during nibble_sel = 1 it SHALL be (byte[7:4], byte[7:4]).
REQ-022 In 10/100 mode, ctl pair SHALL be (en, en^er) from the holding register during both nibble periods.
REQ-023 Nibble and ctl values SHALL change only at cnt == 0, aligned with the rising edge of rgmii_tx_clk.
REQ-024 A speed change SHALL take effect only at a byte boundary: the cycle mac_gmii_tx_clk_en is high, or any cycle in 1G.
REQ-025 At a speed change, cnt and nibble_sel SHALL restart at 0, the holding register loads the current byte, and no partial clock pulse shorter than one 125 MHz half-period is emitted.
REQ-026 gmii inputs SHALL be ignored on cycles where mac_gmii_tx_clk_en is low.

Reset
REQ-027 On rst = 1 at a rising edge, the following SHALL be cleared to 0: cnt, nibble_sel, holding register, all DDR pairs, rgmii_txd, rgmii_tx_ctl, rgmii_tx_clk and mac_gmii_tx_clk_en.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; pads read 0 two cycles later.
REQ-029 After rst deasserts, speed SHALL be sampled on the first cycle; the first clk_en pulse follows 1 cycle later (1G) or 2N cycles later (10/100).

Structure
REQ-030 Speed encodings (SPEED_10, SPEED_100, SPEED_1000) and the period constants 5 and 50 SHALL live in the shared ethernet package.
REQ-031 The DDR output stage SHALL be the sub-module oddr, with parameters TARGET and WIDTH and ports clk, d1, d2, q; it is instantiated once with WIDTH = 6 (clk, ctl, txd).
REQ-032 The oddr GENERIC model SHALL use a posedge register for d1 and a negedge re-register for d2, with output selected by the clk level.

Verification
REQ-033 1G, send bytes 0x55,0xD5,0xA3 with en=1 -> pad nibbles 5,5,5,D,3,A starting 2 cycles after the first sample; ctl (1,1); clk_en high every cycle.
REQ-034 100M, byte 0xA3 with en=1 and er=0 -> clk_en pulses every 10 cycles; txd = 3 for 5 cycles, then A for 5 cycles; rgmii_tx_clk high 2.5 cycles out of every 5.
REQ-035 10M, en=1 and er=1 -> ctl pair (1,0); clk_en period 100 cycles; clock high 25 cycles, low 25 cycles.
REQ-036 Speed switched from 100M to 1G mid-byte -> the switch occurs only at the next clk_en pulse; no clock glitch; the full byte 0xA3 is completed before 1G output starts.
REQ-037 rst asserted at cnt = 3 during a frame -> all outputs are 0 within 2 cycles; after release, the first clk_en pulse comes 2N cycles later.

Source files
------------

// File: rtl/rgmii_tx_if_pkg.sv
// Shared ethernet constants: speed encodings, 10/100 period lengths, DDR pair layout.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package rgmii_tx_if_pkg;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    // 125 MHz cycles per nibble period at 100M (25 MHz) and 10M (2.5 MHz)
    localparam int PERIOD_100M = 5;
    localparam int PERIOD_10M  = 50;

    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST_100M = CNT_W'(PERIOD_100M - 1);
    localparam logic [CNT_W-1:0] LAST_10M  = CNT_W'(PERIOD_10M - 1);

    // One (rising-half, falling-half) value per pad
    typedef struct packed {
        logic       clk_hi;
        logic       clk_lo;
        logic       ctl_hi;
        logic       ctl_lo;
        logic [3:0] txd_hi;
        logic [3:0] txd_lo;
    } ddr_pairs_t;

    // Code 11 is reserved and runs as gigabit
    function automatic logic is_gig(input logic [1:0] spd);
        return (spd == SPEED_1000) || (spd == 2'b11);
    endfunction

    // Terminal count of the nibble-period counter for a 10/100 speed code
    function automatic logic [CNT_W-1:0] period_last(input logic [1:0] spd);
        return (spd == SPEED_10) ? LAST_10M : LAST_100M;
    endfunction

endpackage

// File: rtl/rgmii_tx_if_oddr.sv
// DDR output register: d1 drives the pad while clk is high, d2 while clk is low.
// Latency: d1/d2 captured on the rising edge, d1 visible at once, d2 after the falling edge.
// Backpressure: none; free-running every cycle.
module oddr #(
    parameter string TARGET = "GENERIC",
    parameter int    WIDTH  = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_d1;
    logic [WIDTH-1:0] r_d2;

    // Both halves are captured together on the rising edge (same-edge style)
    always_ff @(posedge clk) begin
        r_d1 <= d1;
        r_d2 <= d2;
    end

    generate
        if (TARGET == "SIM") begin : g_sim
            // Idealised model: the low half is already stable from the rising edge
            assign q = clk ? r_d1 : r_d2;
        end else begin : g_ddr
            // GENERIC, XILINX and ALTERA share the structure of the vendor DDR cells:
            // the low half is re-registered on the falling edge so the mux select
            // (clk level) never races a changing data input.
            logic [WIDTH-1:0] r_d2_neg;

            // Falling-edge re-register of the low-half value
            always_ff @(negedge clk) begin
                r_d2_neg <= r_d2;
            end

            assign q = clk ? r_d1 : r_d2_neg;
        end
    endgenerate

endmodule

// File: rtl/rgmii_tx_if.sv
// GMII to RGMII transmit adapter for 10/100/1000, with forwarded edge-aligned clock.
// Latency: 2 clk from the byte sample edge to its first pad nibble at every speed.
// Backpressure: MAC is paced by mac_gmii_tx_clk_en; bytes are taken only on that strobe.
module rgmii_tx_if
    import rgmii_tx_if_pkg::*;
#(
    parameter string TARGET = "GENERIC"
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] gmii_txd,
    input  logic       gmii_tx_en,
    input  logic       gmii_tx_er,
    input  logic [1:0] speed,
    output logic       mac_gmii_tx_clk_en,
    output logic       rgmii_tx_clk,
    output logic [3:0] rgmii_txd,
    output logic       rgmii_tx_ctl
);

    logic             r_run;      // low for the first cycle after reset: speed not yet sampled
    logic             r_gig;
    logic [CNT_W-1:0] r_n_last;   // N-1 for the active 10/100 speed
    logic [CNT_W-1:0] r_cnt;
    logic             r_nib;      // 0: low nibble period, 1: high nibble period
    logic [7:0]       r_hold_txd;
    logic             r_hold_en;
    logic             r_hold_er;
    ddr_pairs_t       r_pairs;

    logic             w_wrap;
    logic             w_clk_en;
    ddr_pairs_t       w_pairs;
    logic [5:0]       w_oddr_q;

    assign w_wrap   = (r_cnt == r_n_last);
    assign w_clk_en = r_run & (r_gig | (w_wrap & r_nib));
    assign mac_gmii_tx_clk_en = w_clk_en;

    // Period counter and speed selection; a new speed is adopted only at a byte boundary,
    // which in 10/100 coincides with the natural wrap to cnt=0, nibble_sel=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run    <= 1'b0;
            r_gig    <= 1'b0;
            r_n_last <= '0;
            r_cnt    <= '0;
            r_nib    <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (!r_run || w_clk_en) begin
                r_gig    <= is_gig(speed);
                r_n_last <= period_last(speed);
                r_cnt    <= '0;
                r_nib    <= 1'b0;
            end else if (w_wrap) begin
                r_cnt <= '0;
                r_nib <= ~r_nib;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Holding register: GMII inputs are looked at only on the strobe cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_txd <= '0;
            r_hold_en  <= 1'b0;
            r_hold_er  <= 1'b0;
        end else if (w_clk_en) begin
            r_hold_txd <= gmii_txd;
            r_hold_en  <= gmii_tx_en;
            r_hold_er  <= gmii_tx_er;
        end
    end

    // DDR pair generation from the held byte and the position inside the byte period
    always_comb begin
        w_pairs = '0;
        if (r_run) begin
            w_pairs.ctl_hi = r_hold_en;
            w_pairs.ctl_lo = r_hold_en ^ r_hold_er;
            if (r_gig) begin
                w_pairs.clk_hi = 1'b1;
                w_pairs.clk_lo = 1'b0;
                w_pairs.txd_hi = r_hold_txd[3:0];
                w_pairs.txd_lo = r_hold_txd[7:4];
            end else begin
                w_pairs.txd_hi = r_nib ? r_hold_txd[7:4] : r_hold_txd[3:0];
                w_pairs.txd_lo = w_pairs.txd_hi;
                if (r_n_last == LAST_100M) begin
                    // 2.5 cycles high out of 5: the middle cycle drops at its falling edge
                    w_pairs.clk_hi = (r_cnt <= CNT_W'(2));
                    w_pairs.clk_lo = (r_cnt <= CNT_W'(1));
                end else begin
                    w_pairs.clk_hi = (r_cnt <= CNT_W'(24));
                    w_pairs.clk_lo = w_pairs.clk_hi;
                end
            end
        end
    end

    // Pair register feeding the DDR stage; cleared on reset so pads go quiet next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pairs <= '0;
        end else begin
            r_pairs <= w_pairs;
        end
    end

    oddr #(
        .TARGET (TARGET),
        .WIDTH  (6)
    ) u_oddr (
        .clk (clk),
        .d1  ({r_pairs.clk_hi, r_pairs.ctl_hi, r_pairs.txd_hi}),
        .d2  ({r_pairs.clk_lo, r_pairs.ctl_lo, r_pairs.txd_lo}),
        .q   (w_oddr_q)
    );

    assign rgmii_tx_clk = w_oddr_q[5];
    assign rgmii_tx_ctl = w_oddr_q[4];
    assign rgmii_txd    = w_oddr_q[3:0];

endmodule

// File: tb/tb_rgmii_tx_if.sv
// Scoreboard bench for rgmii_tx_if: directed bytes at 1G/100M/10M, speed switch, reset abort.
// Latency: expected nibble records carry the exact pad cycle (sample edge + 2).
// Backpressure: the driver offers a byte only on mac_gmii_tx_clk_en and junk otherwise.
module tb_rgmii_tx_if;
    import rgmii_tx_if_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] gmii_txd = 8'h00;
    logic       gmii_tx_en = 1'b0;
    logic       gmii_tx_er = 1'b0;
    logic [1:0] speed = SPEED_1000;
    logic       mac_gmii_tx_clk_en;
    logic       rgmii_tx_clk;
    logic [3:0] rgmii_txd;
    logic       rgmii_tx_ctl;

    rgmii_tx_if #(.TARGET("GENERIC")) dut (
        .clk                (clk),
        .rst                (rst),
        .gmii_txd           (gmii_txd),
        .gmii_tx_en         (gmii_tx_en),
        .gmii_tx_er         (gmii_tx_er),
        .speed              (speed),
        .mac_gmii_tx_clk_en (mac_gmii_tx_clk_en),
        .rgmii_tx_clk       (rgmii_tx_clk),
        .rgmii_txd          (rgmii_txd),
        .rgmii_tx_ctl       (rgmii_tx_ctl)
    );

    always #4 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // One expected pad cycle while tx_en is on the rising half
    typedef struct {
        logic [3:0] hi;
        logic [3:0] lo;
        logic       ctl_lo;
        int         at;
    } rec_t;

    rec_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every pad cycle with ctl high on the rising half consumes one record
    initial begin : monitor
        logic [5:0] ph;
        logic [5:0] pl;
        int         at;
        rec_t       e;
        forever begin
            @(posedge clk); #2;
            ph = {rgmii_tx_clk, rgmii_tx_ctl, rgmii_txd};
            at = cyc;
            @(negedge clk); #2;
            pl = {rgmii_tx_clk, rgmii_tx_ctl, rgmii_txd};
            if (ph[4]) begin
                check("sb_has_entry", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("txd_hi",       int'(ph[3:0]), int'(e.hi));
                    check("txd_lo",       int'(pl[3:0]), int'(e.lo));
                    check("ctl_lo",       int'(pl[4]),   int'(e.ctl_lo));
                    check("nibble_cycle", at,            e.at);
                end
            end
        end
    end

    // Offer one byte on the next strobe; junk is driven while the strobe is low
    task automatic send_byte(input logic [7:0] b, input logic en, input logic er);
        rec_t r;
        int   n;
        bit   gig;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (mac_gmii_tx_clk_en) break;
            gmii_txd   = 8'hFF;
            gmii_tx_en = 1'b1;
            gmii_tx_er = 1'b1;
        end
        check("clk_en_seen", int'(mac_gmii_tx_clk_en), 1);
        if (!mac_gmii_tx_clk_en) return;
        gmii_txd   = b;
        gmii_tx_en = en;
        gmii_tx_er = er;
        if (en) begin
            gig = is_gig(speed);
            n   = gig ? 1 : ((speed == SPEED_100) ? PERIOD_100M : PERIOD_10M);
            for (int i = 0; i < n; i++) begin
                r.hi = b[3:0];
                r.lo = gig ? b[7:4] : b[3:0];
                r.ctl_lo = en ^ er;
                r.at = cyc + 3 + i;
                sb.push_back(r);
            end
            if (!gig) begin
                for (int i = 0; i < n; i++) begin
                    r.hi = b[7:4];
                    r.lo = b[7:4];
                    r.ctl_lo = en ^ er;
                    r.at = cyc + 3 + n + i;
                    sb.push_back(r);
                end
            end
        end
    endtask

    task automatic wait_clk_en(output int n);
        n = 0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            n++;
            if (mac_gmii_tx_clk_en) break;
        end
    endtask

    task automatic clk_en_period(input int exp, input string name);
        int n;
        wait_clk_en(n);
        wait_clk_en(n);
        check(name, n, exp);
    endtask

    task automatic half(output logic c);
        @(posedge clk or negedge clk); #2;
        c = rgmii_tx_clk;
    endtask

    // Length, in half-cycles, of one high run and the following low run of the pad clock
    task automatic measure_clk(input int exp_hi, input int exp_lo, input string name);
        logic prev;
        logic cur;
        int   hi;
        int   lo;
        half(prev);
        for (int k = 0; k < 400; k++) begin
            half(cur);
            if (!prev && cur) break;
            prev = cur;
        end
        hi = 1;
        for (int k = 0; k < 400; k++) begin
            half(cur);
            if (!cur) break;
            hi++;
        end
        lo = 1;
        for (int k = 0; k < 400; k++) begin
            half(cur);
            if (cur) break;
            lo++;
        end
        check({name, "_high_halves"}, hi, exp_hi);
        check({name, "_low_halves"},  lo, exp_lo);
    endtask

    function automatic int pads();
        return int'({rgmii_tx_clk, rgmii_tx_ctl, rgmii_txd});
    endfunction

    initial begin : stim
        int n;

        // Reset state
        repeat (4) @(posedge clk);
        #2;
        check("rst_clk_en", int'(mac_gmii_tx_clk_en), 0);
        check("rst_pads_hi", pads(), 0);
        @(negedge clk); #2;
        check("rst_pads_lo", pads(), 0);

        // 1G: strobe one cycle after release, then a preamble/SFD/data burst
        @(posedge clk); #1;
        rst = 1'b0;
        wait_clk_en(n);
        check("first_clk_en_1g", n, 1);
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'hD5, 1'b1, 1'b0);
        send_byte(8'hA3, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        clk_en_period(1, "clk_en_period_1g");
        measure_clk(1, 1, "clk_1g");

        // 100M
        speed = SPEED_100;
        send_byte(8'hA3, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        clk_en_period(10, "clk_en_period_100m");
        measure_clk(5, 5, "clk_100m");

        // 100M -> 1G requested mid-byte: A3 must finish at 100M first
        send_byte(8'hA3, 1'b1, 1'b0);
        @(posedge clk); #1;
        gmii_txd   = 8'hFF;
        gmii_tx_en = 1'b1;
        gmii_tx_er = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        speed = SPEED_1000;
        send_byte(8'h5D, 1'b1, 1'b0);
        send_byte(8'h21, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        measure_clk(1, 1, "clk_after_switch");

        // 10M with tx_er: ctl pair (1,0)
        speed = SPEED_10;
        send_byte(8'h96, 1'b1, 1'b1);
        send_byte(8'h00, 1'b0, 1'b0);
        clk_en_period(100, "clk_en_period_10m");
        measure_clk(50, 50, "clk_10m");

        // Reset while cnt = 3 in a 100M byte
        speed = SPEED_100;
        send_byte(8'hA3, 1'b1, 1'b0);
        @(posedge clk); #1;
        gmii_txd   = 8'h00;
        gmii_tx_en = 1'b0;
        gmii_tx_er = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b1;
        speed = SPEED_1000;
        @(posedge clk); #1;
        check("abort_clk_en", int'(mac_gmii_tx_clk_en), 0);
        @(posedge clk); #1; #1;
        check("abort_pads_hi", pads(), 0);
        @(negedge clk); #2;
        check("abort_pads_lo", pads(), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        check("hold_rst_clk_en_1g", int'(mac_gmii_tx_clk_en), 0);
        speed = SPEED_100;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_clk_en(n);
        check("first_clk_en_100m", n, 10);
        send_byte(8'h3C, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);

        for (int k = 0; k < 200; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        repeat (4) @(posedge clk);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
